// File: rtl/lsu_mem_stage.sv
// Load/store access stage: one bus request per memory instruction. The core stalls until the ack arrives, and rd then carries the extended load data.
// Latency is 2 stall cycles when the ack comes in the first REQ cycle. Optional ack watchdog: `define LSU_TIMEOUT_EN.
module lsu_mem_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_op,
    input  logic        mem_we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rd,
    output logic        stall,
    output logic        misalign,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state_q, state_d;
    logic        is_b, is_h, is_uns;
    logic        start;
    logic        capture;
    logic        to_hit;
    logic [3:0]  strb_d;
    logic [31:0] wdat_d;
    logic [31:0] load_ext;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  strb_q, strb_q_d;
    logic [31:0] wdat_q, wdat_q_d;
    logic [1:0]  lane_q, lane_d;
    logic        is_b_q, is_b_d;
    logic        is_h_q, is_h_d;
    logic        is_uns_q, is_uns_d;
    logic [31:0] rd_q, rd_d;

    if (TIMEOUT == 0) begin : g_bad_timeout
        $error("lsu_mem_stage: TIMEOUT must be at least 1");
    end

    // Unlisted funct3 codes fall through to word access.
    always_comb begin
        is_b   = 1'b0;
        is_h   = 1'b0;
        is_uns = 1'b0;
        case (funct3)
            3'b000: is_b = 1'b1;
            3'b001: is_h = 1'b1;
            3'b100: begin is_b = 1'b1; is_uns = 1'b1; end
            3'b101: begin is_h = 1'b1; is_uns = 1'b1; end
            default: ;
        endcase
    end

    assign misalign = mem_op && ((is_h && addr[0]) || (!is_b && !is_h && (addr[1:0] != 2'b00)));
    assign start    = mem_op && !misalign;
    assign stall    = start && (state_q != DONE);

    always_comb begin
        strb_d = 4'b0000;
        wdat_d = 32'h0;
        if (mem_we) begin
            if (is_b) begin
                strb_d = 4'b0001 << addr[1:0];
                wdat_d = {4{wdata[7:0]}};
            end else if (is_h) begin
                strb_d = 4'b0011 << addr[1:0];
                wdat_d = {2{wdata[15:0]}};
            end else begin
                strb_d = 4'b1111;
                wdat_d = wdata;
            end
        end
    end

`ifdef LSU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] to_cnt_q, to_cnt_d;
    logic          err_q, err_d;

    assign to_hit = (state_q == REQ) && !bus_ack && (to_cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        to_cnt_d = to_cnt_q;
        if (capture) begin
            to_cnt_d = '0;
        end else if ((state_q == REQ) && !bus_ack) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
        err_d = to_hit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            err_q    <= err_d;
        end
    end

    assign bus_err = err_q;
`else
    assign to_hit  = 1'b0;
    assign bus_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = REQ;
            REQ:     if (bus_ack || to_hit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus_req = (state_q == REQ);
        capture = (state_q == IDLE) && start;
    end

    // Extraction uses the captured lane/size, so addr may wander during REQ.
    always_comb begin
        case (lane_q)
            2'd0:    ld_byte = bus_rdata[7:0];
            2'd1:    ld_byte = bus_rdata[15:8];
            2'd2:    ld_byte = bus_rdata[23:16];
            default: ld_byte = bus_rdata[31:24];
        endcase
        ld_half = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        if (is_b_q) begin
            load_ext = {{24{ld_byte[7] & ~is_uns_q}}, ld_byte};
        end else if (is_h_q) begin
            load_ext = {{16{ld_half[15] & ~is_uns_q}}, ld_half};
        end else begin
            load_ext = bus_rdata;
        end
    end

    always_comb begin
        we_d     = we_q;
        addr_d   = addr_q;
        strb_q_d = strb_q;
        wdat_q_d = wdat_q;
        lane_d   = lane_q;
        is_b_d   = is_b_q;
        is_h_d   = is_h_q;
        is_uns_d = is_uns_q;
        rd_d     = rd_q;
        if (capture) begin
            we_d     = mem_we;
            addr_d   = {addr[31:2], 2'b00};
            strb_q_d = strb_d;
            wdat_q_d = wdat_d;
            lane_d   = addr[1:0];
            is_b_d   = is_b;
            is_h_d   = is_h;
            is_uns_d = is_uns;
        end
        if ((state_q == REQ) && bus_ack && !we_q) begin
            rd_d = load_ext;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q     <= 1'b0;
            addr_q   <= 32'h0;
            strb_q   <= 4'b0000;
            wdat_q   <= 32'h0;
            lane_q   <= 2'b00;
            is_b_q   <= 1'b0;
            is_h_q   <= 1'b0;
            is_uns_q <= 1'b0;
            rd_q     <= 32'h0;
        end else begin
            we_q     <= we_d;
            addr_q   <= addr_d;
            strb_q   <= strb_q_d;
            wdat_q   <= wdat_q_d;
            lane_q   <= lane_d;
            is_b_q   <= is_b_d;
            is_h_q   <= is_h_d;
            is_uns_q <= is_uns_d;
            rd_q     <= rd_d;
        end
    end

    assign rd        = rd_q;
    assign bus_we    = we_q;
    assign bus_addr  = addr_q;
    assign bus_wstrb = strb_q;
    assign bus_wdata = wdat_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Scoreboard bench for lsu_mem_stage: expectations are queued at issue and retired when the DUT reaches DONE.
module tb_lsu_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_op, mem_we;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic [31:0] rd;
    logic        stall, misalign, bus_err, bus_req, bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] rd;
        int          stalls;
        logic        err;
    } exp_t;

    exp_t sb[$];

    lsu_mem_stage #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .mem_op(mem_op), .mem_we(mem_we), .funct3(funct3),
        .addr(addr), .wdata(wdata), .rd(rd), .stall(stall), .misalign(misalign),
        .bus_err(bus_err), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ack_dly: index of the REQ cycle that carries bus_ack (-1 = never).
    task automatic access(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                          input int ack_dly, input logic [31:0] exp_rd, input int exp_stalls,
                          input logic exp_err, input logic [3:0] exp_strb, input logic [31:0] exp_wdat);
        exp_t e;
        int   stalls = 0;
        int   reqc   = 0;
        bit   done   = 0;
        @(posedge clk);
        #1;
        mem_op = 1'b1; mem_we = we; funct3 = f3; addr = a; wdata = wd; bus_ack = 1'b0;
        e.rd = exp_rd; e.stalls = exp_stalls; e.err = exp_err;
        sb.push_back(e);
        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            @(negedge clk);
            if (stall) stalls++;
            if (bus_req) begin
                if (reqc == 0) begin
                    chk({tag, "_we"}, 32'(bus_we), 32'(we));
                    chk({tag, "_strb"}, 32'(bus_wstrb), 32'(exp_strb));
                    if (we) chk({tag, "_wdata"}, bus_wdata, exp_wdat);
                    addr = a + 32'h0000_1000;
                end
                chk({tag, "_addr"}, bus_addr, {a[31:2], 2'b00});
                bus_ack   = (reqc == ack_dly);
                bus_rdata = (reqc == ack_dly) ? rdat : $urandom;
                reqc++;
            end else if (mem_op && !stall && !misalign) begin
                e = sb.pop_front();
                chk({tag, "_rd"}, rd, e.rd);
                chk({tag, "_stalls"}, 32'(stalls), 32'(e.stalls));
                chk({tag, "_err"}, 32'(bus_err), 32'(e.err));
                done    = 1;
                mem_op  = 1'b0;
                bus_ack = 1'b0;
            end else begin
                bus_ack = 1'b0;
            end
        end
        if (!done) begin
            chk({tag, "_no_done"}, 32'd0, 32'd1);
            void'(sb.pop_front());
            mem_op  = 1'b0;
            bus_ack = 1'b0;
        end
        @(negedge clk);
        chk({tag, "_err_after"}, 32'(bus_err), 32'd0);
    endtask

    task automatic mis_check(input string tag, input logic we, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] exp_rd);
        @(posedge clk);
        #1;
        mem_op = 1'b1; mem_we = we; funct3 = f3; addr = a;
        @(negedge clk);
        chk({tag, "_misalign"}, 32'(misalign), 32'd1);
        chk({tag, "_stall"}, 32'(stall), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk({tag, "_req"}, 32'(bus_req), 32'd0);
        end
        chk({tag, "_rd"}, rd, exp_rd);
        mem_op = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; mem_op = 1'b0; mem_we = 1'b0; funct3 = 3'b010; addr = 32'h0;
        wdata = 32'h0; bus_rdata = 32'h0; bus_ack = 1'b0;
        #3;
        chk("rst_rd", rd, 32'h0);
        chk("rst_req", 32'(bus_req), 32'd0);
        chk("rst_we", 32'(bus_we), 32'd0);
        chk("rst_addr", bus_addr, 32'h0);
        chk("rst_strb", 32'(bus_wstrb), 32'd0);
        chk("rst_wdata", bus_wdata, 32'h0);
        chk("rst_err", 32'(bus_err), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_misalign", 32'(misalign), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        access("lw",    1'b0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 0, 32'hDEADBEEF, 2, 1'b0, 4'b0000, 32'h0);
        access("lb",    1'b0, 3'b000, 32'h103, 32'h0,        32'h80FF0000, 1, 32'hFFFFFF80, 3, 1'b0, 4'b0000, 32'h0);
        access("lbu",   1'b0, 3'b100, 32'h103, 32'h0,        32'h80FF0000, 0, 32'h00000080, 2, 1'b0, 4'b0000, 32'h0);
        access("sh",    1'b1, 3'b001, 32'h102, 32'h1234ABCD, 32'hFFFFFFFF, 3, 32'h00000080, 5, 1'b0, 4'b1100, 32'hABCDABCD);
        access("lh",    1'b0, 3'b001, 32'h102, 32'h0,        32'h80FF0000, 0, 32'hFFFF80FF, 2, 1'b0, 4'b0000, 32'h0);
        access("lhu",   1'b0, 3'b101, 32'h102, 32'h0,        32'h80FF0000, 0, 32'h000080FF, 2, 1'b0, 4'b0000, 32'h0);
        access("lb_pos",1'b0, 3'b000, 32'h101, 32'h0,        32'h12345678, 0, 32'h00000056, 2, 1'b0, 4'b0000, 32'h0);
        access("sb",    1'b1, 3'b000, 32'h101, 32'h000000A5, 32'h0,        0, 32'h00000056, 2, 1'b0, 4'b0010, 32'hA5A5A5A5);
        access("sw",    1'b1, 3'b010, 32'h200, 32'hCAFEF00D, 32'h0,        2, 32'h00000056, 4, 1'b0, 4'b1111, 32'hCAFEF00D);
        access("lh_lo", 1'b0, 3'b001, 32'h000, 32'h0,        32'h00017FFF, 0, 32'h00007FFF, 2, 1'b0, 4'b0000, 32'h0);
        access("l_f3x", 1'b0, 3'b111, 32'h204, 32'h0,        32'h0BADCAFE, 0, 32'h0BADCAFE, 2, 1'b0, 4'b0000, 32'h0);

        mis_check("mis_lw", 1'b0, 3'b010, 32'h101, 32'h0BADCAFE);
        mis_check("mis_lh", 1'b0, 3'b001, 32'h103, 32'h0BADCAFE);
        mis_check("mis_sw", 1'b1, 3'b010, 32'h102, 32'h0BADCAFE);
        addr = 32'h101; funct3 = 3'b010;
        #1;
        chk("mis_idle_op", 32'(misalign), 32'd0);

        // Stray ack with no transaction in flight.
        @(negedge clk);
        bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        bus_ack = 1'b0;
        chk("stray_ack_rd", rd, 32'h0BADCAFE);
        chk("stray_ack_req", 32'(bus_req), 32'd0);

        // Reset in the second REQ cycle, then a late ack.
        @(posedge clk);
        #1;
        mem_op = 1'b1; mem_we = 1'b0; funct3 = 3'b010; addr = 32'h300;
        @(negedge clk);
        @(negedge clk);
        chk("rstmid_req1", 32'(bus_req), 32'd1);
        @(negedge clk);
        chk("rstmid_req2", 32'(bus_req), 32'd1);
        rst = 1'b1;
        #1;
        chk("rstmid_req_drop", 32'(bus_req), 32'd0);
        chk("rstmid_rd", rd, 32'h0);
        mem_op = 1'b0;
        @(negedge clk);
        rst = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h55555555;
        @(negedge clk);
        bus_ack = 1'b0;
        chk("late_ack_req", 32'(bus_req), 32'd0);
        chk("late_ack_rd", rd, 32'h0);
        chk("late_ack_stall", 32'(stall), 32'd0);

        access("lw_post", 1'b0, 3'b010, 32'h104, 32'h0, 32'h11112222, 0, 32'h11112222, 2, 1'b0, 4'b0000, 32'h0);

`ifdef LSU_TIMEOUT_EN
        access("to_noack", 1'b0, 3'b010, 32'h108, 32'h0, 32'h99999999, -1, 32'h11112222, 5, 1'b1, 4'b0000, 32'h0);
        access("to_ackwin", 1'b0, 3'b010, 32'h10C, 32'h0, 32'h33334444, 3, 32'h33334444, 5, 1'b0, 4'b0000, 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
